// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: function codes, FSM states and
// the iterative mul/div latency.
package alu_pkg;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_MUL  = 4'b0001;
   localparam logic [3:0] OP_DIV  = 4'b0010;
   localparam logic [3:0] OP_SMUL = 4'b0011;
   localparam logic [3:0] OP_SDIV = 4'b0100;
   localparam logic [3:0] OP_ROR  = 4'b1000;
   localparam logic [3:0] OP_ROL  = 4'b1001;
   localparam logic [3:0] OP_SLL  = 4'b1010;
   localparam logic [3:0] OP_SLR  = 4'b1011;
   localparam logic [3:0] OP_OR   = 4'b1100;
   localparam logic [3:0] OP_AND  = 4'b1101;
   localparam logic [3:0] OP_SUB  = 4'b1110;
   localparam logic [3:0] OP_ADD  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIVD = 2'd2
   } state_t;

   // One engine iteration per result bit, so MULDIV_LAT equals DATA_WIDTH.
   function automatic int muldiv_lat(input int data_width);
      return data_width;
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider. The first
// iteration runs on the start edge; done flags the edge of the last one.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ITERS      = DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  is_div,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] res_hi,
   output logic [DATA_WIDTH-1:0] res_lo
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(ITERS);
   localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

   logic          busy_q, busy_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, opd_q, opd_d;
   logic          div_q, div_d;

   logic [W-1:0]  src_hi, src_lo, src_b, step_hi, step_lo;
   logic          src_div;
   logic [W:0]    shifted, trial, sum;

   always_comb begin
      src_hi  = start ? '0     : hi_q;
      src_lo  = start ? a      : lo_q;
      src_b   = start ? b      : opd_q;
      src_div = start ? is_div : div_q;

      // hi holds the partial remainder (div) or running upper product (mul)
      shifted = {src_hi, src_lo[W-1]};
      trial   = shifted - {1'b0, src_b};
      sum     = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_b} : '0);
      if (src_div) begin
         if (shifted >= {1'b0, src_b}) begin
            step_hi = trial[W-1:0];
            step_lo = {src_lo[W-2:0], 1'b1};
         end else begin
            step_hi = shifted[W-1:0];
            step_lo = {src_lo[W-2:0], 1'b0};
         end
      end else begin
         step_hi = sum[W:1];
         step_lo = {sum[0], src_lo[W-1:1]};
      end

      hi_d  = hi_q;
      lo_d  = lo_q;
      opd_d = opd_q;
      div_d = div_q;
      if (start || busy_q) begin
         hi_d  = step_hi;
         lo_d  = step_lo;
         opd_d = src_b;
         div_d = src_div;
      end

      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (start) begin
         busy_d = 1'b1;
         cnt_d  = CW'(1);
      end else if (busy_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) busy_d = 1'b0;
      end
   end

   assign done   = busy_q && (cnt_q == LAST);
   assign res_hi = step_hi;
   assign res_lo = step_lo;

   always_ff @(posedge clk) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      opd_q <= opd_d;
      div_q <= div_d;
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and iterative MUL/DIV.
// Define ALU_SIGNED_MULDIV_EN to add SMUL (0011) and SDIV (0100).
module alu_seq
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH        = 16,
   parameter int ALU_CONTROL_WIDTH = 4,
   parameter int SHAMT_WIDTH       = $clog2(DATA_WIDTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_WIDTH-1:0]        A,
   input  logic [DATA_WIDTH-1:0]        B,
   input  logic [ALU_CONTROL_WIDTH-1:0] ALU_Ctrl,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        R,
   output logic [DATA_WIDTH-1:0]        S,
   output logic                         ALU_Exception
);

   localparam int W          = DATA_WIDTH;
   localparam int MULDIV_LAT = muldiv_lat(DATA_WIDTH);

   state_t         state_q, state_d;
   logic           out_valid_q, out_valid_d;
   logic [W-1:0]   r_q, r_d, s_q, s_d;
   logic           exc_q, exc_d;
   logic           neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, ovf_q, ovf_d;

   logic           accept, ctrl_hi_nz;
   logic [3:0]     op;
   logic           eng_start, eng_div, eng_done;
   logic [W-1:0]   eng_a, eng_b, eng_hi, eng_lo, quo, rem;
   logic [2*W-1:0] prod, sll_res, rol_tmp, ror_tmp;
   logic signed [W-1:0] a_s, b_s, sum_s, dif_s;

`ifdef ALU_SIGNED_MULDIV_EN
   function automatic logic [W-1:0] mag(input logic signed [W-1:0] x);
      return x[W-1] ? W'(-x) : W'(x);
   endfunction
`endif

   assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready) && !rst;
   assign accept     = in_valid && in_ready;
   assign op         = ALU_Ctrl[3:0];
   assign ctrl_hi_nz = (ALU_Ctrl >> 4) != '0;

   assign a_s     = A;
   assign b_s     = B;
   assign sum_s   = a_s + b_s;
   assign dif_s   = a_s - b_s;
   assign sll_res = {{W{1'b0}}, A} << B;
   assign rol_tmp = {A, A} << B[SHAMT_WIDTH-1:0];
   assign ror_tmp = {A, A} >> B[SHAMT_WIDTH-1:0];

   // Sign correction for the signed variants happens on the final engine cycle
   assign prod = neg_lo_q ? -{eng_hi, eng_lo} : {eng_hi, eng_lo};
   assign quo  = neg_lo_q ? -eng_lo : eng_lo;
   assign rem  = neg_hi_q ? -eng_hi : eng_hi;

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !out_ready;
      r_d         = r_q;
      s_d         = s_q;
      exc_d       = exc_q;
      neg_lo_d    = neg_lo_q;
      neg_hi_d    = neg_hi_q;
      ovf_d       = ovf_q;
      eng_start   = 1'b0;
      eng_div     = 1'b0;
      eng_a       = A;
      eng_b       = B;

      case (state_q)
         IDLE: if (accept) begin
            out_valid_d = 1'b1;
            r_d         = '0;
            s_d         = '0;
            exc_d       = 1'b0;
            neg_lo_d    = 1'b0;
            neg_hi_d    = 1'b0;
            ovf_d       = 1'b0;
            if (ctrl_hi_nz) begin
               exc_d = 1'b1;
            end else begin
               case (op)
                  OP_NOP: ;
                  OP_ADD: begin
                     r_d   = sum_s;
                     exc_d = (a_s[W-1] == b_s[W-1]) && (sum_s[W-1] != a_s[W-1]);
                  end
                  OP_SUB: begin
                     r_d   = dif_s;
                     exc_d = (a_s[W-1] != b_s[W-1]) && (dif_s[W-1] != a_s[W-1]);
                  end
                  OP_AND: r_d = A & B;
                  OP_OR:  r_d = A | B;
                  OP_SLL: {s_d, r_d} = sll_res;
                  OP_SLR: r_d = A >> B;
                  OP_ROL: r_d = rol_tmp[2*W-1:W];
                  OP_ROR: r_d = ror_tmp[W-1:0];
                  OP_MUL: begin
                     out_valid_d = 1'b0;
                     eng_start   = 1'b1;
                     state_d     = MULT;
                  end
                  OP_DIV: begin
                     if (B == '0) begin
                        r_d   = '1;
                        s_d   = A;
                        exc_d = 1'b1;
                     end else begin
                        out_valid_d = 1'b0;
                        eng_start   = 1'b1;
                        eng_div     = 1'b1;
                        state_d     = DIVD;
                     end
                  end
`ifdef ALU_SIGNED_MULDIV_EN
                  OP_SMUL: begin
                     out_valid_d = 1'b0;
                     eng_start   = 1'b1;
                     eng_a       = mag(a_s);
                     eng_b       = mag(b_s);
                     neg_lo_d    = a_s[W-1] ^ b_s[W-1];
                     state_d     = MULT;
                  end
                  OP_SDIV: begin
                     if (B == '0) begin
                        r_d   = '1;
                        s_d   = A;
                        exc_d = 1'b1;
                     end else begin
                        out_valid_d = 1'b0;
                        eng_start   = 1'b1;
                        eng_div     = 1'b1;
                        eng_a       = mag(a_s);
                        eng_b       = mag(b_s);
                        neg_lo_d    = a_s[W-1] ^ b_s[W-1];
                        neg_hi_d    = a_s[W-1];
                        ovf_d       = (A == {1'b1, {(W-1){1'b0}}}) && (B == '1);
                        state_d     = DIVD;
                     end
                  end
`endif
                  default: exc_d = 1'b1;
               endcase
            end
         end
         MULT: if (eng_done) begin
            {s_d, r_d}  = prod;
            exc_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         DIVD: if (eng_done) begin
            r_d         = quo;
            s_d         = rem;
            exc_d       = ovf_q;
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      ovf_q    <= ovf_d;
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         r_q         <= '0;
         s_q         <= '0;
         exc_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         r_q         <= r_d;
         s_q         <= s_d;
         exc_q       <= exc_d;
      end
   end

   alu_muldiv_iter #(
      .DATA_WIDTH (DATA_WIDTH),
      .ITERS      (MULDIV_LAT)
   ) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (eng_start),
      .is_div (eng_div),
      .a      (eng_a),
      .b      (eng_b),
      .done   (eng_done),
      .res_hi (eng_hi),
      .res_lo (eng_lo)
   );

   assign out_valid     = out_valid_q;
   assign R             = r_q;
   assign S             = s_q;
   assign ALU_Exception = exc_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, handshake/reset
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, ALU_Exception;
   logic [15:0] A, B, R, S;
   logic [3:0]  ALU_Ctrl;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_seq dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .A             (A),
      .B             (B),
      .ALU_Ctrl      (ALU_Ctrl),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .R             (R),
      .S             (S),
      .ALU_Exception (ALU_Exception)
   );

   typedef struct {
      string       name;
      logic [3:0]  c;
      logic [15:0] a, b, r, s;
      logic        e;
      int          lat;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected result straight from the arithmetic definition of each code.
   function automatic void ref_model(input logic [3:0] c, input logic [15:0] a, b,
                                     output logic [15:0] r, s, output logic e, output int lat);
      longint ua = a;
      longint ub = b;
      longint sa = $signed(a);
      longint sb = $signed(b);
      longint t;
      r = 0; s = 0; e = 0; lat = 1;
      case (c)
         4'hF: begin t = sa + sb; r = 16'(t); e = (t > 32767) || (t < -32768); end
         4'hE: begin t = sa - sb; r = 16'(t); e = (t > 32767) || (t < -32768); end
         4'hD: r = a & b;
         4'hC: r = a | b;
         4'h1: begin t = ua * ub; r = 16'(t); s = 16'(t >> 16); lat = 16; end
         4'h2: begin
            if (b == 0) begin r = 16'hFFFF; s = a; e = 1; end
            else begin r = 16'(ua / ub); s = 16'(ua % ub); lat = 16; end
         end
         4'hA: begin t = (ub >= 32) ? 0 : (ua << ub); r = 16'(t); s = 16'(t >> 16); end
         4'hB: r = (ub >= 16) ? 16'h0 : 16'(ua >> ub);
         4'h9: begin t = ub % 16; r = 16'((ua << t) | (ua >> (16 - t))); end
         4'h8: begin t = ub % 16; r = 16'((ua >> t) | (ua << (16 - t))); end
         4'h0: ;
`ifdef ALU_SIGNED_MULDIV_EN
         4'h3: begin t = sa * sb; r = 16'(t); s = 16'(t >> 16); lat = 16; end
         4'h4: begin
            if (b == 0) begin r = 16'hFFFF; s = a; e = 1; end
            else if (sa == -32768 && sb == -1) begin r = 16'h8000; s = 0; e = 1; lat = 16; end
            else begin r = 16'(sa / sb); s = 16'(sa % sb); lat = 16; end
         end
`endif
         default: e = 1;
      endcase
   endfunction

   // Issue one op with out_ready=1; returns the result and the number of edges
   // from the accepting edge (inclusive) until out_valid is seen.
   task automatic run_op(input logic [3:0] c, input logic [15:0] a, b,
                         output logic [15:0] r, s, output logic e,
                         output int lat, output logic rdy_bad);
      int guard;
      @(negedge clk);
      ALU_Ctrl = c; A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      A = 16'($urandom); B = 16'($urandom); ALU_Ctrl = 4'($urandom);
      lat = 1;
      rdy_bad = 1'b0;
      while (!out_valid && lat < 64) begin
         if (in_ready) rdy_bad = 1'b1;
         @(negedge clk);
         lat++;
      end
      r = R; s = S; e = ALU_Exception;
   endtask

   initial begin
      logic [15:0] r, s, er, es;
      logic        e, ee, rb;
      int          lat, elat;
      logic [3:0]  c;
      logic [15:0] a, b;
      logic [15:0] exp_r [4];

      vecs[0]  = '{"add_ovf",  4'hF, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1};
      vecs[1]  = '{"and",      4'hD, 16'h0F0F, 16'h00FF, 16'h000F, 16'h0000, 1'b0, 1};
      vecs[2]  = '{"mul",      4'h1, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0, 16};
      vecs[3]  = '{"div",      4'h2, 16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 16};
      vecs[4]  = '{"div0",     4'h2, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1, 1};
      vecs[5]  = '{"ror",      4'h8, 16'h0001, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1};
      vecs[6]  = '{"rol17",    4'h9, 16'h8001, 16'd17,   16'h0003, 16'h0000, 1'b0, 1};
      vecs[7]  = '{"slr16",    4'hB, 16'hFFFF, 16'd16,   16'h0000, 16'h0000, 1'b0, 1};
      vecs[8]  = '{"invalid",  4'h5, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b1, 1};
      vecs[9]  = '{"sub_ovf",  4'hE, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b1, 1};
      vecs[10] = '{"or",       4'hC, 16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000, 1'b0, 1};
      vecs[11] = '{"sll4",     4'hA, 16'h8001, 16'd4,    16'h0010, 16'h0008, 1'b0, 1};
      vecs[12] = '{"sll32",    4'hA, 16'h0001, 16'd32,   16'h0000, 16'h0000, 1'b0, 1};
      vecs[13] = '{"nop",      4'h0, 16'h1234, 16'h4321, 16'h0000, 16'h0000, 1'b0, 1};
      vecs[14] = '{"add",      4'hF, 16'd2,    16'd3,    16'h0005, 16'h0000, 1'b0, 1};
      vecs[15] = '{"mul_max",  4'h1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 16};
      vecs[16] = '{"div_by1",  4'h2, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 16};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; ALU_Ctrl = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_R", R, 0);
      check("rst_S", S, 0);
      check("rst_exc", ALU_Exception, 0);
      check("idle_in_ready", in_ready, 1);

      foreach (vecs[i]) begin
         run_op(vecs[i].c, vecs[i].a, vecs[i].b, r, s, e, lat, rb);
         check({vecs[i].name, "_R"}, r, vecs[i].r);
         check({vecs[i].name, "_S"}, s, vecs[i].s);
         check({vecs[i].name, "_exc"}, e, vecs[i].e);
         check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
         if (vecs[i].lat > 1) check({vecs[i].name, "_busy_ready"}, rb, 0);
      end

      // Back-pressure: result held for three cycles, then a 4-op stream.
      @(negedge clk);
      ALU_Ctrl = 4'hF; A = 16'h1111; B = 16'h2222; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      ALU_Ctrl = 4'hF; A = 16'h0100; B = 16'h0002;
      for (int k = 0; k < 4; k++) begin
         ref_model(4'hF, 16'h0100 * 16'(k + 1), 16'(k + 2), er, es, ee, elat);
         exp_r[k] = er;
      end
      for (int k = 0; k < 3; k++) begin
         check("hold_valid", out_valid, 1);
         check("hold_R", R, 16'h3333);
         check("hold_S", S, 0);
         check("hold_in_ready", in_ready, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("stream_valid", out_valid, 1);
         check("stream_R", R, exp_r[k]);
         if (k < 3) begin
            A = 16'h0100 * 16'(k + 2); B = 16'(k + 3);
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      check("stream_drained", out_valid, 0);

      // Reset in the middle of a multiply discards it.
      ALU_Ctrl = 4'h1; A = 16'h1234; B = 16'h0100; in_valid = 1'b1; out_ready = 1'b1;
      check("mulrst_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mulrst_valid", out_valid, 0);
      check("mulrst_R", R, 0);
      check("mulrst_S", S, 0);
      check("mulrst_in_ready", in_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      check("mulrst_idle", in_ready, 1);
      run_op(4'hF, 16'd2, 16'd3, r, s, e, lat, rb);
      check("post_rst_R", r, 5);
      check("post_rst_lat", lat, 1);
      repeat (20) @(negedge clk);
      check("post_rst_no_stale", out_valid, 0);

      for (int n = 0; n < 250; n++) begin
         c = 4'($urandom_range(0, 15));
         a = 16'($urandom);
         b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
         if ($urandom_range(0, 9) == 0) b = 16'h0;
         ref_model(c, a, b, er, es, ee, elat);
         run_op(c, a, b, r, s, e, lat, rb);
         if (r !== er || s !== es || e !== ee || lat != elat) begin
            $display("FAIL rand op=%h a=%h b=%h: got R=%h S=%h E=%b lat=%0d expected R=%h S=%h E=%b lat=%0d",
                     c, a, b, r, s, e, lat, er, es, ee, elat);
            n_fail++;
         end
         n_tests++;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the combinational ALU. It keeps the same function-code map and adds:
- a valid/ready handshake on both input and output;
- iterative multi-cycle MUL and DIV engines;
- divide-by-zero detection;
- correct AND/OR mapping.

It sits between operand fetch and writeback. Results and the exception flag are registered and held until the consumer accepts them.

Parameters:
DATA_WIDTH, 16, operand/result width (>=4, power of two)
ALU_CONTROL_WIDTH, 4, function-code width
SHAMT_WIDTH, $clog2(DATA_WIDTH), rotate-amount width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept op
A  in  DATA_WIDTH  operand A
B  in  DATA_WIDTH  operand B / shift amount
ALU_Ctrl  in  ALU_CONTROL_WIDTH  function code
out_valid  out  1  result registers valid
out_ready  in  1  consumer accepts result
R  out  DATA_WIDTH  result low half / quotient
S  out  DATA_WIDTH  high half / remainder
ALU_Exception  out  1  overflow, div-by-0 or invalid code

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset is synchronous and active-high, rst.
- Reset: state=IDLE, out_valid=0, R=0, S=0, ALU_Exception=0. in_ready is forced 0 while rst=1. Reset mid-operation aborts the operation; the result is discarded.
- Accept: in_valid && in_ready at a rising edge. in_ready = (state==IDLE) && (!out_valid || out_ready) && !rst.
- Output: out_valid stays high and R/S/ALU_Exception stay stable until out_valid && out_ready. A result consumed on the same edge a new op is accepted is replaced with no bubble.
- States:
  - IDLE: on accept, MUL → MULT and DIV (B!=0) → DIVD; all other ops complete here.
  - MULT/DIVD: a counter runs 0..DATA_WIDTH-1, one iteration per edge. At count DATA_WIDTH-1 the result loads and the state returns to IDLE.
- Latency from accepting edge to out_valid:
  - 1 edge for single-cycle ops, NOP, invalid code and DIV by 0;
  - DATA_WIDTH edges for MUL and DIV.
  - in_ready=0 throughout MULT/DIVD.
- Codes:
  - ADD 1111: S=0. Exception when sign(A)==sign(B) && sign(R)!=sign(A).
  - SUB 1110: S=0. Exception when sign(A)!=sign(B) && sign(R)!=sign(A).
  - AND 1101 = A&B; OR 1100 = A|B; S=0 for both.
  - MUL 0001: unsigned shift-add. {S,R} = A*B.
  - DIV 0010: unsigned restoring division. R = A/B, S = A%B.
  - SLL 1010: {S,R} = A<<B over 2*DATA_WIDTH bits. B >= 2*DATA_WIDTH gives 0.
  - SLR 1011: R = A>>B, S=0. B >= DATA_WIDTH gives 0.
  - ROL 1001 / ROR 1000: rotate by B[SHAMT_WIDTH-1:0], i.e. B mod DATA_WIDTH; S=0.
  - 0000 NOP: R=S=0, no exception, out_valid still produced.
- DIV with B==0: R=all ones, S=A, ALU_Exception=1, 1-edge latency.
- Invalid code: R=S=0, ALU_Exception=1. No simulation-only $display may affect behaviour.
- Operands and code are captured at accept. Later input changes are ignored.

Optional Feature:
- Macro: ALU_SIGNED_MULDIV_EN.
- Defined: adds SMUL 0011 and SDIV 0100.
  - Inputs are two's complement; magnitudes feed the same iterative engine and the result sign is corrected in the final cycle.
  - SDIV: quotient truncates toward zero; remainder takes the sign of A.
  - Most-negative / -1 gives R=most-negative, S=0, ALU_Exception=1.
  - Same latency as MUL/DIV.
- Undefined: 0011 and 0100 are invalid codes.

Decomposition:
- Package alu_pkg holds:
  - function-code localparams;
  - the state enum {IDLE, MULT, DIVD};
  - the MULDIV_LAT = DATA_WIDTH constant.
- One sub-module, alu_muldiv_iter: the iterative shift-add/restoring-divide datapath with start/done and counter. The top level keeps the handshake, the single-cycle ops and the exception logic.

Test Plan:
1. ADD A=0x7FFF, B=0x0001 → 1 edge later out_valid=1, R=0x8000, S=0, ALU_Exception=1. AND 0x0F0F, 0x00FF → R=0x000F.
2. MUL A=0x1234, B=0x0100 → R=0x3400, S=0x0012, out_valid exactly 16 edges after accept, in_ready=0 during.
3. DIV 100/7 → R=0x000E, S=0x0002 after 16 edges. DIV 5/0 → 1 edge later R=0xFFFF, S=0x0005, exception=1.
4. ROR 0x0001 by 1 → 0x8000. ROL 0x8001 by 17 → 0x0003. SLR 0xFFFF by 16 → 0. Code 0101 → R=0, exception=1.
5. out_ready held 0 for 3 cycles after a result → R/S stable, in_ready=0. Then 4 back-to-back ADDs with out_ready=1 → one result per cycle, none lost.
6. rst pulsed during MUL iteration 5 → next edge out_valid=0, R=S=0. After release, ADD 2+3 → R=5 in 1 edge.
